// File: rtl/adt7310_spi_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : adt7310_pkg                                                |
// | Shared register addresses, command-byte layout, config-field layout  |
// | and FSM state encoding for the ADT7310 SPI responder.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adt7310_pkg;

    // Register addresses
    localparam logic [2:0] STATUS = 3'd0;
    localparam logic [2:0] CONFIG = 3'd1;
    localparam logic [2:0] TEMP   = 3'd2;
    localparam logic [2:0] ID     = 3'd3;

    // Command byte bit positions
    localparam int CMD_BIT_ZERO = 7;   // must be 0
    localparam int CMD_BIT_RW   = 6;   // 1 = read
    localparam int CMD_ADDR_MSB = 5;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_BIT_CONT = 2;   // continuous read, ignored
    localparam int CMD_PAD_MSB  = 1;   // bits [1:0] must be 00
    localparam int CMD_PAD_LSB  = 0;

    // Config register operating-mode field
    localparam int         CFG_MODE_MSB = 6;
    localparam int         CFG_MODE_LSB = 5;
    localparam logic [1:0] ONESHOT_MODE = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_RDATA  = 3'd2,
        ST_WDATA  = 3'd3,
        ST_IGNORE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // A command is well formed when the fixed-zero bits are all zero.
    function automatic logic cmd_valid(input logic [7:0] cmd);
        return (cmd[CMD_BIT_ZERO] == 1'b0) &&
               (cmd[CMD_PAD_MSB:CMD_PAD_LSB] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adt7310_spi_responder_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_slave_sync                                             |
// | STAGES-deep synchronizer with rise/fall detection on the last stage. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_slave_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the pin into the chain; remember the previous last-stage value
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = i_d;
        prev_d    = sync_q[STAGES-1];
    end

    // Synchronizer flops, idle level on reset so no edge is seen after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_rise =  sync_q[STAGES-1] & ~prev_q;
    assign o_fall = ~sync_q[STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/adt7310_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : adt7310_spi_responder                                      |
// | SPI mode-3 slave that answers like an ADT7310 for status, config,    |
// | temperature and ID registers. Temperature comes from the host port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adt7310_spi_responder
    import adt7310_pkg::*;
#(
    parameter int         SyncStages       = 2,
    parameter logic [7:0] IdValue          = 8'hC3,
    parameter logic [7:0] ConfigResetValue = 8'h00
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        SCK_i,
    input  logic        CS_n_i,
    input  logic        MOSI_i,
    output logic        MISO_o,
    output logic        MISO_En_o,
    input  logic [15:0] TempValue_i,
    input  logic        TempUpdate_i,
    output logic [7:0]  Config_o,
    output logic        OneShot_o
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise_unused;

    spi_slave_sync #(.STAGES(SyncStages), .RESET_VAL(1'b1)) u_sck_sync (
        .clk    (Clk_i),
        .rst    (Reset_i),
        .i_d    (SCK_i),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_slave_sync #(.STAGES(SyncStages), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (Clk_i),
        .rst    (Reset_i),
        .i_d    (CS_n_i),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    assign w_sck_rise_unused = 1'b0;

    // MOSI uses the same depth as SCK so the sampled bit matches the pin edge
    logic [SyncStages-1:0] mosi_sync_q;
    logic [SyncStages-1:0] mosi_sync_d;
    logic                  w_mosi;

    always_comb begin
        mosi_sync_d    = mosi_sync_q << 1;
        mosi_sync_d[0] = MOSI_i;
    end

    assign w_mosi = mosi_sync_q[SyncStages-1];

    state_t      state_q,     state_d;
    logic [3:0]  bit_cnt_q,   bit_cnt_d;
    logic [6:0]  shift_in_q,  shift_in_d;
    logic [15:0] shift_out_q, shift_out_d;
    logic        wide_q,      wide_d;
    logic        miso_q,      miso_d;
    logic        miso_en_q,   miso_en_d;
    logic [7:0]  config_q,    config_d;
    logic        oneshot_q,   oneshot_d;
    logic [15:0] temp_q,      temp_d;
    logic        rdy_n_q,     rdy_n_d;

    logic [7:0]  w_byte;
    logic [15:0] w_rd_data;
    logic        w_rd_wide;
    logic        w_temp_read;
    logic [3:0]  w_last_rd_bit;

    // Next-state logic: transaction FSM, shift registers and register file
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        wide_d      = wide_q;
        miso_d      = miso_q;
        miso_en_d   = miso_en_q;
        config_d    = config_q;
        oneshot_d   = 1'b0;
        temp_d      = temp_q;
        rdy_n_d     = rdy_n_q;
        w_temp_read = 1'b0;

        // Byte as it will be once the current MOSI bit is shifted in
        w_byte        = {shift_in_q, w_mosi};
        w_last_rd_bit = wide_q ? 4'd15 : 4'd7;

        // Read data is left-aligned; 8-bit registers pad the low byte with 1s
        w_rd_wide = 1'b0;
        case (w_byte[CMD_ADDR_MSB:CMD_ADDR_LSB])
            STATUS:  w_rd_data = {rdy_n_q, 7'b0, 8'hFF};
            CONFIG:  w_rd_data = {config_q, 8'hFF};
            TEMP: begin
                w_rd_data = temp_q;
                w_rd_wide = 1'b1;
            end
            ID:      w_rd_data = {IdValue, 8'hFF};
            default: w_rd_data = {8'h00, 8'hFF};
        endcase

        if (w_cs_rise) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 4'd0;
            shift_in_d = 7'd0;
            miso_d     = 1'b1;
            miso_en_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        state_d    = ST_CMD;
                        bit_cnt_d  = 4'd0;
                        shift_in_d = 7'd0;
                        miso_d     = 1'b1;
                        miso_en_d  = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (w_sck_rise) begin
                        shift_in_d = w_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (!cmd_valid(w_byte)) begin
                                state_d = ST_IGNORE;
                            end else if (w_byte[CMD_BIT_RW]) begin
                                state_d     = ST_RDATA;
                                shift_out_d = w_rd_data;
                                wide_d      = w_rd_wide;
                                w_temp_read = (w_byte[CMD_ADDR_MSB:CMD_ADDR_LSB] == TEMP);
                            end else if (w_byte[CMD_ADDR_MSB:CMD_ADDR_LSB] == CONFIG) begin
                                state_d = ST_WDATA;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_sck_fall) begin
                        miso_d      = shift_out_q[15];
                        shift_out_d = {shift_out_q[14:0], 1'b1};
                        bit_cnt_d   = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == w_last_rd_bit) begin
                            bit_cnt_d = 4'd0;
                            state_d   = ST_DONE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_sck_rise) begin
                        shift_in_d = w_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            config_d  = w_byte;
                            oneshot_d = (w_byte[CFG_MODE_MSB:CFG_MODE_LSB] == ONESHOT_MODE);
                            state_d   = ST_DONE;
                        end
                    end
                end
                ST_IGNORE, ST_DONE: begin
                    // Last read bit is held until the following falling edge
                    if (w_sck_fall) begin
                        miso_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A host update in the same cycle as a temperature read keeps RDY_n low
        if (TempUpdate_i) begin
            temp_d  = TempValue_i;
            rdy_n_d = 1'b0;
        end else if (w_temp_read) begin
            rdy_n_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_in_q  <= 7'd0;
            shift_out_q <= 16'hFFFF;
            wide_q      <= 1'b0;
            miso_q      <= 1'b1;
            miso_en_q   <= 1'b0;
            config_q    <= ConfigResetValue;
            oneshot_q   <= 1'b0;
            temp_q      <= 16'h0000;
            rdy_n_q     <= 1'b1;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            wide_q      <= wide_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
            config_q    <= config_d;
            oneshot_q   <= oneshot_d;
            temp_q      <= temp_d;
            rdy_n_q     <= rdy_n_d;
        end
    end

    assign MISO_o    = miso_q | w_sck_rise_unused;
    assign MISO_En_o = miso_en_q;
    assign Config_o  = config_q;
    assign OneShot_o = oneshot_q;

endmodule
`default_nettype wire

// File: tb/tb_adt7310_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_adt7310_spi_responder                                   |
// | Self-checking bench: directed vector table, hand-written corner      |
// | sequences and randomized transactions against a register model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_adt7310_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_en;
    logic [15:0] temp_val;
    logic        temp_upd;
    logic [7:0]  cfg;
    logic        oneshot;

    always #5 clk = ~clk;

    adt7310_spi_responder dut (
        .Clk_i        (clk),
        .Reset_i      (rst),
        .SCK_i        (sck),
        .CS_n_i       (cs_n),
        .MOSI_i       (mosi),
        .MISO_o       (miso),
        .MISO_En_o    (miso_en),
        .TempValue_i  (temp_val),
        .TempUpdate_i (temp_upd),
        .Config_o     (cfg),
        .OneShot_o    (oneshot)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic en_seen;

    always @(negedge clk) if (oneshot === 1'b1) pulse_cnt++;

    // Reference register state
    logic [7:0]  m_cfg;
    logic [15:0] m_temp;
    logic        m_rdy_n;

    typedef struct {
        logic [31:0] mosi;
        int          n;
        logic [31:0] exp_miso;
        logic [7:0]  exp_cfg;
        int          exp_pulses;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 3: master changes MOSI on falling SCK, samples MISO on rising SCK
    task automatic spi_bits(input logic [31:0] bits, input int n, input int upd_bit,
                            input logic [15:0] upd_val, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sck  = 1'b0;
            mosi = bits[n-1-i];
            wait_clk(HALF);
            rx = {rx[30:0], miso};
            if (i == 0) en_seen = miso_en;
            sck = 1'b1;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (i == upd_bit && c == 2) begin
                    temp_val = upd_val;
                    temp_upd = 1'b1;
                end else begin
                    temp_upd = 1'b0;
                end
            end
        end
    endtask

    task automatic xfer(input logic [31:0] bits, input int n, input int upd_bit,
                        input logic [15:0] upd_val, output logic [31:0] rx);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(bits, n, upd_bit, upd_val, rx);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic temp_update(input logic [15:0] v);
        @(negedge clk);
        temp_val = v;
        temp_upd = 1'b1;
        @(negedge clk);
        temp_upd = 1'b0;
        m_temp  = v;
        m_rdy_n = 1'b0;
    endtask

    // Behavioural view of one CS-framed transaction of n bits
    task automatic model_xfer(input logic [31:0] bits, input int n,
                              output logic [31:0] exp_rx, output int pulses);
        logic [7:0]  cmd;
        logic [7:0]  wbyte;
        logic [15:0] d;
        int          w;
        int          pos;
        exp_rx = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        pulses = 0;
        if (n < 8) return;
        cmd = 8'(bits >> (n - 8));
        if (cmd[7] || cmd[1:0] != 2'b00) return;
        if (cmd[6]) begin
            w = 8;
            case (cmd[5:3])
                3'd0: d = {8'h00, m_rdy_n, 7'b0};
                3'd1: d = {8'h00, m_cfg};
                3'd2: begin d = m_temp; w = 16; end
                3'd3: d = 16'h00C3;
                default: d = 16'h0000;
            endcase
            for (int k = 0; k < w; k++) begin
                pos = n - 9 - k;
                if (pos >= 0) exp_rx[pos] = d[w-1-k];
            end
            if (cmd[5:3] == 3'd2) m_rdy_n = 1'b1;
        end else if (cmd[5:3] == 3'd1 && n >= 16) begin
            wbyte = 8'(bits >> (n - 16));
            m_cfg = wbyte;
            if (wbyte[6:5] == 2'b01) pulses = 1;
        end
    endtask

    logic [31:0] rx;
    logic [31:0] exp_rx;
    int          p0;
    int          exp_p;

    initial begin
        rst      = 1'b1;
        sck      = 1'b1;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        temp_upd = 1'b0;
        temp_val = 16'h0000;
        en_seen  = 1'b0;

        tbl[0]  = '{32'h0000_4000, 16, 32'h0000_FF00, 8'h00, 0};
        tbl[1]  = '{32'h0050_0000, 24, 32'h00FF_0C80, 8'h00, 0};
        tbl[2]  = '{32'h0000_4000, 16, 32'h0000_FF80, 8'h00, 0};
        tbl[3]  = '{32'h0000_0820, 16, 32'h0000_FFFF, 8'h20, 1};
        tbl[4]  = '{32'h0000_0840, 16, 32'h0000_FFFF, 8'h40, 0};
        tbl[5]  = '{32'h0000_4800, 16, 32'h0000_FF40, 8'h40, 0};
        tbl[6]  = '{32'h0000_5800, 16, 32'h0000_FFC3, 8'h40, 0};
        tbl[7]  = '{32'h0000_7800, 16, 32'h0000_FF00, 8'h40, 0};
        tbl[8]  = '{32'h0000_008F, 12, 32'h0000_0FFF, 8'h40, 0};
        tbl[9]  = '{32'h0000_4800, 16, 32'h0000_FF40, 8'h40, 0};
        tbl[10] = '{32'h00D0_0000, 24, 32'h00FF_FFFF, 8'h40, 0};
        tbl[11] = '{32'h0058_0000, 24, 32'h00FF_C3FF, 8'h40, 0};
        tbl[12] = '{32'h0000_1855, 16, 32'h0000_FFFF, 8'h40, 0};
        tbl[13] = '{32'h0000_5800, 16, 32'h0000_FFC3, 8'h40, 0};

        wait_clk(3);
        check("rst_miso", miso, 1'b1);
        check("rst_en", miso_en, 1'b0);
        check("rst_cfg", cfg, 8'h00);
        check("rst_oneshot", oneshot, 1'b0);
        rst = 1'b0;
        wait_clk(4);

        // Directed vectors
        temp_update(16'h0C80);
        for (int i = 0; i < 14; i++) begin
            p0 = pulse_cnt;
            xfer(tbl[i].mosi, tbl[i].n, -1, 16'h0, rx);
            check($sformatf("vec%0d_miso", i), rx, tbl[i].exp_miso);
            check($sformatf("vec%0d_cfg", i), cfg, tbl[i].exp_cfg);
            check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, tbl[i].exp_pulses);
            check($sformatf("vec%0d_en", i), en_seen, 1'b1);
        end
        check("idle_en", miso_en, 1'b0);

        // Host update coincides with decode of a temperature read
        temp_update(16'h1234);
        xfer(32'h0050_0000, 24, 7, 16'hABCD, rx);
        check("simul_old_temp", rx, 32'h00FF_1234);
        xfer(32'h0000_4000, 16, -1, 16'h0, rx);
        check("simul_rdy_low", rx, 32'h0000_FF00);
        xfer(32'h0050_0000, 24, -1, 16'h0, rx);
        check("simul_new_temp", rx, 32'h00FF_ABCD);
        xfer(32'h0000_4000, 16, -1, 16'h0, rx);
        check("simul_rdy_high", rx, 32'h0000_FF80);

        // Reset asserted mid-read of config (0x40, MSB 0 on the line)
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(32'h0000_0090, 9, -1, 16'h0, rx);
        check("pre_rst_miso", miso, 1'b0);
        check("pre_rst_en", miso_en, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_miso", miso, 1'b1);
        check("mid_rst_en", miso_en, 1'b0);
        check("mid_rst_cfg", cfg, 8'h00);
        check("mid_rst_oneshot", oneshot, 1'b0);
        cs_n = 1'b1;
        sck  = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);

        // Randomized transactions against the model
        m_cfg   = 8'h00;
        m_temp  = 16'h0000;
        m_rdy_n = 1'b1;
        for (int t = 0; t < 40; t++) begin
            logic [7:0]  cmd;
            logic [31:0] bits;
            int          n;
            int          kind;
            if ($urandom_range(0, 2) == 0) temp_update(16'($urandom));
            kind = $urandom_range(0, 7);
            if (kind == 0)
                cmd = 8'($urandom);
            else if (kind <= 4)
                cmd = {2'b01, 3'($urandom_range(0, 7)), 1'($urandom), 2'b00};
            else
                cmd = {2'b00, ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom_range(0, 7)),
                       1'($urandom), 2'b00};
            n    = 8 + $urandom_range(1, 24);
            bits = {cmd, 24'($urandom)} >> (32 - n);
            p0   = pulse_cnt;
            xfer(bits, n, -1, 16'h0, rx);
            model_xfer(bits, n, exp_rx, exp_p);
            check($sformatf("rnd%0d_miso", t), rx, exp_rx);
            check($sformatf("rnd%0d_cfg", t), cfg, m_cfg);
            check($sformatf("rnd%0d_pulses", t), pulse_cnt - p0, exp_p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
